// File: rtl/fifo_mc_pkg.sv
// Shared helpers for the multi-channel FIFO: select width, packed count
// slicing and the almost-full threshold sanity check.
package fifo_mc_pkg;

  function automatic int ch_bits(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_lsb(input int c, input int ab);
    return c * (ab + 1);
  endfunction

  function automatic bit af_ok(input int margin, input int ab);
    return (margin >= 0) && (margin < (1 << ab));
  endfunction

endpackage

// File: rtl/fifo_mc_chan_ctrl.sv
// Per-channel queue bookkeeping: pointers, occupancy, status and sticky
// error bits. Storage lives in the top level.
module fifo_mc_chan_ctrl
  import fifo_mc_pkg::*;
#(
  parameter int addr_bits = 3,
  parameter int af_margin = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_hit,
  input  logic                 rd_hit,
  input  logic                 flush,
  input  logic                 wr_err,
  input  logic                 rd_err,
  input  logic                 err_clear,
  output logic [addr_bits-1:0] rptr,
  output logic [addr_bits-1:0] wptr,
  output logic [addr_bits:0]   count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int CW = addr_bits + 1;
  localparam logic [CW-1:0] DEPTH  = CW'(1 << addr_bits);
  localparam logic [CW-1:0] AF_LVL = CW'((1 << addr_bits) - af_margin);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      // Dropping the contents is just catching the read pointer up.
      count <= '0;
      rptr  <= wptr;
    end else begin
      if (wr_hit) wptr <= wptr + 1'b1;
      if (rd_hit) rptr <= rptr + 1'b1;
      count <= count + CW'(wr_hit) - CW'(rd_hit);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_err) overflow  <= 1'b1;
      if (rd_err) underflow <= 1'b1;
    end
  end

  assign empty       = (count == '0);
  assign full        = (count == DEPTH);
  assign almost_full = (count >= AF_LVL);

endmodule

// File: rtl/fifo_mc.sv
// Multi-channel FIFO: shared storage, one write and one read port steered by
// channel selects, with fall-through on empty and read+write on full.
module fifo_mc
  import fifo_mc_pkg::*;
#(
  parameter int width     = 40,
  parameter int addr_bits = 3,
  parameter int channels  = 4,
  parameter int af_margin = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                wen,
  input  logic [ch_bits(channels)-1:0]        wch,
  input  logic [width-1:0]                    wdata,
  output logic                                waccept,
  input  logic                                ren,
  input  logic [ch_bits(channels)-1:0]        rch,
  output logic [width-1:0]                    rdata,
  output logic                                raccept,
  input  logic [channels-1:0]                 flush,
  input  logic                                err_clear,
  output logic [channels-1:0]                 empty,
  output logic [channels-1:0]                 full,
  output logic [channels-1:0]                 almost_full,
  output logic [channels*(addr_bits+1)-1:0]   count,
  output logic [channels-1:0]                 overflow,
  output logic [channels-1:0]                 underflow
);

  localparam int CHB   = ch_bits(channels);
  localparam int DEPTH = 1 << addr_bits;

  if (!af_ok(af_margin, addr_bits)) begin : g_bad_af
    $error("fifo_mc: af_margin must be below the channel depth");
  end

  logic [width-1:0]     mem [channels][DEPTH];
  logic [addr_bits-1:0] rptr [channels];
  logic [addr_bits-1:0] wptr [channels];
  logic [channels-1:0]  wr_hit, rd_hit, wr_err, rd_err;
  logic                 same;

  assign same    = wen && ren && (wch == rch);
  assign waccept = wen && !flush[wch] && (!full[wch] || same);
  assign raccept = ren && !flush[rch] && (!empty[rch] || same);

  // An empty channel forwards the incoming word straight to the reader.
  assign rdata = empty[rch] ? wdata : mem[rch][rptr[rch]];

  always_ff @(posedge clock) begin
    if (waccept) mem[wch][wptr[wch]] <= wdata;
  end

  for (genvar c = 0; c < channels; c++) begin : g_ch
    assign wr_hit[c] = waccept && (wch == CHB'(c));
    assign rd_hit[c] = raccept && (rch == CHB'(c));
    assign wr_err[c] = wen && (wch == CHB'(c)) && !waccept && !flush[c];
    assign rd_err[c] = ren && (rch == CHB'(c)) && !raccept && !flush[c];

    fifo_mc_chan_ctrl #(
      .addr_bits (addr_bits),
      .af_margin (af_margin)
    ) u_ctrl (
      .clock       (clock),
      .reset       (reset),
      .wr_hit      (wr_hit[c]),
      .rd_hit      (rd_hit[c]),
      .flush       (flush[c]),
      .wr_err      (wr_err[c]),
      .rd_err      (rd_err[c]),
      .err_clear   (err_clear),
      .rptr        (rptr[c]),
      .wptr        (wptr[c]),
      .count       (count[cnt_lsb(c, addr_bits) +: addr_bits+1]),
      .empty       (empty[c]),
      .full        (full[c]),
      .almost_full (almost_full[c]),
      .overflow    (overflow[c]),
      .underflow   (underflow[c])
    );
  end

endmodule

// File: tb/tb_fifo_mc.sv
// Directed bench for fifo_mc with a per-channel queue scoreboard.
module tb_fifo_mc;

  localparam int W = 40;
  localparam int D = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wen = 1'b0, ren = 1'b0, err_clear = 1'b0;
  logic [1:0]    wch = '0, rch = '0;
  logic [W-1:0]  wdata = '0;
  logic [3:0]    flush = '0;
  logic          waccept, raccept;
  logic [W-1:0]  rdata;
  logic [3:0]    empty, full, almost_full, overflow, underflow;
  logic [15:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] sb [4][$];
  logic [3:0]   m_ov = '0, m_un = '0;

  always #5 clock = ~clock;

  fifo_mc #(.width(W), .addr_bits(3), .channels(4), .af_margin(2)) dut (
    .clock(clock), .reset(reset), .wen(wen), .wch(wch), .wdata(wdata),
    .waccept(waccept), .ren(ren), .rch(rch), .rdata(rdata), .raccept(raccept),
    .flush(flush), .err_clear(err_clear), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s count[%0d]", tag, c), 64'(count[c*4 +: 4]), 64'(sb[c].size()));
      check($sformatf("%s empty[%0d]", tag, c), 64'(empty[c]), 64'(sb[c].size() == 0));
      check($sformatf("%s full[%0d]", tag, c), 64'(full[c]), 64'(sb[c].size() == D));
      check($sformatf("%s af[%0d]", tag, c), 64'(almost_full[c]), 64'(sb[c].size() >= D - 2));
      check($sformatf("%s ovf[%0d]", tag, c), 64'(overflow[c]), 64'(m_ov[c]));
      check($sformatf("%s unf[%0d]", tag, c), 64'(underflow[c]), 64'(m_un[c]));
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own queues.
  task automatic cycle(input bit we, input int wc, input logic [W-1:0] wd,
                       input bit re, input int rc, input logic [3:0] fl, input bit ec);
    bit same, e_wa, e_ra;
    logic [W-1:0] e_rd;
    wen = we; wch = 2'(wc); wdata = wd; ren = re; rch = 2'(rc);
    flush = fl; err_clear = ec;
    same = we && re && (wc == rc);
    e_wa = we && !fl[wc] && (sb[wc].size() < D || same);
    e_ra = re && !fl[rc] && (sb[rc].size() != 0 || same);
    @(negedge clock);
    check("waccept", 64'(waccept), 64'(e_wa));
    check("raccept", 64'(raccept), 64'(e_ra));
    if (e_wa) sb[wc].push_back(wd);
    if (e_ra) begin
      e_rd = sb[rc].pop_front();
      check("rdata", 64'(rdata), 64'(e_rd));
    end
    if (we && !e_wa && !fl[wc]) m_ov[wc] = 1'b1;
    if (re && !e_ra && !fl[rc]) m_un[rc] = 1'b1;
    if (ec) begin m_ov = '0; m_un = '0; end
    for (int c = 0; c < 4; c++) if (fl[c]) sb[c].delete();
    @(posedge clock); #1;
    wen = 0; ren = 0; flush = '0; err_clear = 0;
  endtask

  initial begin
    #12;
    check_status("reset");
    check("reset empty", 64'(empty), 64'hF);
    reset = 1'b0;
    @(posedge clock); #1;

    // Fill ch2, then one refused write.
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 2, W'(i), 0, 0, 4'h0, 0);
      check_status($sformatf("fill2_%0d", i));
      if (i == 5) check("af2 before 6th", 64'(almost_full[2]), 64'd0);
      if (i == 6) check("af2 at 6th", 64'(almost_full[2]), 64'd1);
    end
    check("full2", 64'(full[2]), 64'd1);
    cycle(1, 2, W'(9), 0, 0, 4'h0, 0);
    check("ovf2 set", 64'(overflow[2]), 64'd1);
    check_status("ovf2");

    // Bypass on empty ch1.
    cycle(1, 1, W'('hAA), 1, 1, 4'h0, 0);
    check("bypass empty1", 64'(empty[1]), 64'd1);
    check_status("bypass1");

    // Full ch3 with simultaneous read+write, then drain.
    for (int i = 0; i < 8; i++) cycle(1, 3, W'('h10 + i), 0, 0, 4'h0, 0);
    check_status("fill3");
    cycle(1, 3, W'('h99), 1, 3, 4'h0, 0);
    check_status("rw_full3");
    for (int i = 0; i < 8; i++) cycle(0, 0, '0, 1, 3, 4'h0, 0);
    check_status("drain3");

    // ch2 down to 3 words, then cross-channel write/read.
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, 2, 4'h0, 0);
    check_status("ch2_3");
    cycle(1, 0, W'('h55), 1, 2, 4'h0, 0);
    check_status("cross");

    // Flush ch1 while writing to it.
    for (int i = 0; i < 5; i++) cycle(1, 1, W'('h30 + i), 0, 0, 4'h0, 0);
    cycle(1, 1, W'('h3F), 0, 0, 4'h2, 0);
    check("flush ovf1", 64'(overflow[1]), 64'd0);
    check_status("flush1");
    cycle(1, 1, W'('h41), 0, 0, 4'h0, 0);
    cycle(0, 0, '0, 1, 1, 4'h0, 0);
    cycle(1, 1, W'('h42), 1, 1, 4'h0, 0);
    check_status("post_flush1");

    // Underflow on ch0, then clear.
    cycle(0, 0, '0, 1, 0, 4'h0, 0);
    cycle(0, 0, '0, 1, 0, 4'h0, 0);
    check("unf0 set", 64'(underflow[0]), 64'd1);
    check_status("unf0");
    cycle(1, 0, W'('h77), 1, 0, 4'h0, 1);
    check_status("err_clear");

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) cycle(1, i, W'('h60 + i), 0, 0, 4'h0, 0);
    #2 reset = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) sb[c].delete();
    m_ov = '0; m_un = '0;
    check("async rst counts", 64'(count), 64'd0);
    check_status("async_rst");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    cycle(1, 2, W'('h123), 0, 0, 4'h0, 0);
    cycle(0, 0, '0, 1, 2, 4'h0, 0);
    check_status("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_mc.md
Name: fifo_mc

Overview:
- Multi-channel successor to the single-queue search-task FIFO: `channels` independent circular queues share one storage array, with one write port and one read port, each steered by a channel select.
- Keeps first-word fall-through/bypass on an empty queue and simultaneous read+write on a full queue.
- Adds per-channel status bitmaps, a programmable almost-full threshold, per-channel flush, and sticky overflow/underflow error flags.
- Sits between the board-task dispatcher (writer) and the solver-core arbiter (reader); one channel per core group.

Parameters:
- width, 40, data word width in bits.
- addr_bits, 3, per-channel depth is 2**addr_bits.
- channels, 4, number of queues; must be >= 2 and a power of two.
- af_margin, 2, almost_full asserts when count >= depth - af_margin.

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wen  in  1  write request.
- wch  in  $clog2(channels)  write channel select.
- wdata  in  width  write data.
- waccept  out  1  write taken this cycle.
- ren  in  1  read request.
- rch  in  $clog2(channels)  read channel select.
- rdata  out  width  head of channel rch (combinational).
- raccept  out  1  read taken this cycle.
- flush  in  channels  per-channel synchronous empty request.
- err_clear  in  1  clears all sticky error bits.
- empty  out  channels  per-channel count == 0.
- full  out  channels  per-channel count == depth.
- almost_full  out  channels  per-channel count >= depth - af_margin.
- count  out  channels*(addr_bits+1)  packed per-channel counts; channel c occupies bits [c*(addr_bits+1) +: addr_bits+1].
- overflow  out  channels  sticky: a write to a full channel was refused.
- underflow  out  channels  sticky: a read of an empty channel was refused.

Behaviour:
- Reset (async): all counts, read pointers and write pointers = 0; overflow = underflow = 0.
  - Outputs after reset: empty all 1, full = almost_full = 0 (af_margin < depth), waccept = raccept = 0 unless requested.
  - Storage is not reset. Reset mid-operation discards all queued data immediately.
- `same` = (wen && ren && wch == rch).
- waccept = wen && !flush[wch] && (!full[wch] || (same && ren)).
- raccept = ren && !flush[rch] && (!empty[rch] || same).
- rdata = mem[rch][rptr[rch]] when count[rch] != 0, else wdata (fall-through). Zero read latency.
- On an empty channel with `same`, the word bypasses: raccept = waccept = 1, the count stays 0, pointers both advance, and storage is written but the word is consumed.
- Per channel c, on the clock edge:
  - count += (waccept && wch == c) - (raccept && rch == c).
  - wptr advances on write; rptr advances on read; both wrap modulo depth.
- Full channel with `same`: both accepted, count stays at depth, the head is output, the new word lands in the freed slot (written at wptr == rptr, read first).
- Flush[c]: at the edge, count = 0 and rptr = wptr for channel c. Any read/write on c in that cycle is refused and does not set error flags. Flush of other channels does not affect c.
- Errors:
  - overflow[c] set when wen && wch == c && !waccept && !flush[c].
  - underflow[c] set when ren && rch == c && !raccept && !flush[c].
  - err_clear takes priority over a same-cycle set.
- Operations on different channels in the same cycle are fully independent.
- Status outputs are derived from registered counts: no combinational path from wen/ren to empty/full/almost_full/count.

Decomposition:
- fifo_pkg: function for channel-select width ($clog2(channels)), packed count slice helper, and the af_margin sanity constraint (af_margin < depth).
- One sub-module, fifo_mc_chan_ctrl, instantiated per channel via generate:
  - Inputs: wr_hit, rd_hit, flush.
  - State: rptr, wptr, count, overflow/underflow bits.
  - Outputs: empty, full, almost_full.
- The top level holds the shared storage array, accept logic and rdata mux.

Test Plan:
- Reset, then 8 writes to ch2 (0x01..0x08) -> full[2]=1 and almost_full[2]=1 from the 6th write; count ch2 = 8; 9th write refused and overflow[2]=1; ch0/1/3 still empty.
- Write 0xAA to empty ch1 with ren, rch=1 in the same cycle -> rdata=0xAA, raccept=waccept=1, count ch1 stays 0, empty[1]=1.
- Ch3 full (0x10..0x17), simultaneous write 0x99 and read on ch3 -> rdata=0x10, count stays 8; eight more reads return 0x11..0x17, then 0x99.
- Write ch0 and read ch2 in the same cycle with ch2 holding 3 words -> both accepted; ch0 count +1, ch2 count -1.
- 5 words in ch1, flush[1] asserted with wen on ch1 -> count ch1 = 0, write refused, overflow[1]=0; the next write+read round-trips correctly.
- Read empty ch0 -> underflow[0]=1; err_clear -> 0. Assert reset mid-burst -> all counts 0 asynchronously before the next edge.
